// File: rtl/cpu2.sv
// cpu2: accumulator machine with a three-state FETCH/DECODE/EXECUTE sequencer,
// a 2^A_W-word internal memory preloaded with a switch-to-display program,
// and two seven-segment decoders driven from the output register.
module cpu2 #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] switches,
  output logic [6:0]        disp0,
  output logic [6:0]        disp1
);

  localparam int A_W   = WORD_W - OP_W;
  localparam int DEPTH = 1 << A_W;

  // Opcode map
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(3'd0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(3'd1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3'd2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3'd3);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(3'd4);
  localparam logic [OP_W-1:0] OP_IN    = OP_W'(3'd5);
  localparam logic [OP_W-1:0] OP_OUT   = OP_W'(3'd6);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(3'd7);

  // Accumulator source selection
  localparam logic [1:0] ACC_MDR = 2'd0;
  localparam logic [1:0] ACC_ADD = 2'd1;
  localparam logic [1:0] ACC_SUB = 2'd2;
  localparam logic [1:0] ACC_SW  = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2
  } state_t;

  // Active-high seven-segment decode, bit order g,f,e,d,c,b,a.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Architectural state
  state_t            state;
  state_t            state_next;
  logic [A_W-1:0]    pc;
  logic [WORD_W-1:0] ir;
  logic [A_W-1:0]    mar;
  logic [WORD_W-1:0] mdr;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] outreg;

  // Memory powers up holding IN / OUT / JMP 0; reset never touches it.
  logic [WORD_W-1:0] mem [0:DEPTH-1] = '{
    0:       {OP_IN,  {A_W{1'b0}}},
    1:       {OP_OUT, {A_W{1'b0}}},
    2:       {OP_JMP, {A_W{1'b0}}},
    default: {WORD_W{1'b0}}
  };

  // Instruction fields
  logic [OP_W-1:0] opcode;
  logic [A_W-1:0]  addr_field;
  assign opcode     = ir[WORD_W-1:A_W];
  assign addr_field = ir[A_W-1:0];

  // Sequencer control outputs
  logic       ir_load;
  logic       pc_inc;
  logic       pc_jump;
  logic       mar_load;
  logic       mdr_load;
  logic       acc_load;
  logic [1:0] acc_sel;
  logic       mem_we;
  logic       out_load;

  // Datapath helpers
  logic [WORD_W-1:0] acc_next;
  logic [A_W-1:0]    pc_next;
  logic              acc_nonzero;
  assign acc_nonzero = (acc != {WORD_W{1'b0}});

  // Sequencer state register; reset always returns to FETCH.
  always_ff @(posedge clock) begin
    if (n_reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Sequencer next-state: fixed three-cycle rotation, unused code recovers to FETCH.
  always_comb begin
    state_next = ST_FETCH;
    case (state)
      ST_FETCH:   state_next = ST_DECODE;
      ST_DECODE:  state_next = ST_EXECUTE;
      ST_EXECUTE: state_next = ST_FETCH;
      default:    state_next = ST_FETCH;
    endcase
  end

  // Sequencer outputs: per-state register enables, opcode decode in EXECUTE.
  always_comb begin
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_jump  = 1'b0;
    mar_load = 1'b0;
    mdr_load = 1'b0;
    acc_load = 1'b0;
    acc_sel  = ACC_MDR;
    mem_we   = 1'b0;
    out_load = 1'b0;
    case (state)
      ST_FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      ST_DECODE: begin
        mar_load = 1'b1;
        mdr_load = 1'b1;
      end
      ST_EXECUTE: begin
        case (opcode)
          OP_LOAD: begin
            acc_load = 1'b1;
            acc_sel  = ACC_MDR;
          end
          OP_STORE: mem_we = 1'b1;
          OP_ADD: begin
            acc_load = 1'b1;
            acc_sel  = ACC_ADD;
          end
          OP_SUB: begin
            acc_load = 1'b1;
            acc_sel  = ACC_SUB;
          end
          OP_BNE: begin
            if (acc_nonzero) begin
              pc_jump = 1'b1;
            end else begin
              pc_jump = 1'b0;
            end
          end
          OP_IN: begin
            acc_load = 1'b1;
            acc_sel  = ACC_SW;
          end
          OP_OUT:  out_load = 1'b1;
          OP_JMP:  pc_jump  = 1'b1;
          default: acc_load = 1'b0;
        endcase
      end
      default: ir_load = 1'b0;
    endcase
  end

  // Accumulator source mux; arithmetic wraps modulo 2^WORD_W.
  always_comb begin
    acc_next = mdr;
    case (acc_sel)
      ACC_MDR: acc_next = mdr;
      ACC_ADD: acc_next = acc + mdr;
      ACC_SUB: acc_next = acc - mdr;
      ACC_SW:  acc_next = switches;
      default: acc_next = mdr;
    endcase
  end

  // Program counter source: increment in FETCH, branch target in EXECUTE, else hold.
  always_comb begin
    if (pc_inc) begin
      pc_next = pc + {{(A_W-1){1'b0}}, 1'b1};
    end else if (pc_jump) begin
      pc_next = mar;
    end else begin
      pc_next = pc;
    end
  end

  // Datapath registers; reset clears them and aborts any instruction in flight.
  always_ff @(posedge clock) begin
    if (n_reset) begin
      pc     <= {A_W{1'b0}};
      ir     <= {WORD_W{1'b0}};
      mar    <= {A_W{1'b0}};
      mdr    <= {WORD_W{1'b0}};
      acc    <= {WORD_W{1'b0}};
      outreg <= {WORD_W{1'b0}};
    end else begin
      pc <= pc_next;
      if (ir_load) begin
        ir <= mem[pc];
      end
      if (mar_load) begin
        mar <= addr_field;
      end
      if (mdr_load) begin
        mdr <= mem[addr_field];
      end
      if (acc_load) begin
        acc <= acc_next;
      end
      if (out_load) begin
        outreg <= acc;
      end
    end
  end

  // Memory write port: only STORE writes, and never on a reset edge.
  always @(posedge clock) begin
    if (mem_we && !n_reset) begin
      mem[mar] <= acc;
    end
  end

  // Displays decode the output register directly.
  always_comb begin
    disp0 = seg_decode(outreg[3:0]);
    disp1 = seg_decode(outreg[7:4]);
  end

endmodule

// File: tb/tb_cpu2.sv
// Self-checking bench for cpu2: an instruction-level reference model is
// stepped once per 3-cycle instruction and compared against the DUT.
module tb_cpu2;

  logic       clock;
  logic       n_reset;
  logic [7:0] switches;
  logic [6:0] disp0;
  logic [6:0] disp1;

  int checks;
  int fails;

  // Reference model state (instruction-level view)
  logic [7:0] m_mem [0:31];
  logic [4:0] m_pc;
  logic [7:0] m_acc;
  logic [7:0] m_out;

  logic [6:0] seg_tab [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  cpu2 #(.WORD_W(8), .OP_W(3)) dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .switches (switches),
    .disp0    (disp0),
    .disp1    (disp1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_power_up();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_mem[0] = 8'hA0;
    m_mem[1] = 8'hC0;
    m_mem[2] = 8'hE0;
  endtask

  task automatic model_reset();
    m_pc  = 5'd0;
    m_acc = 8'h00;
    m_out = 8'h00;
  endtask

  // One whole instruction, straight from the instruction set rules.
  task automatic model_step();
    logic [7:0] instr;
    logic [2:0] op;
    logic [4:0] a;
    instr = m_mem[m_pc];
    m_pc  = m_pc + 5'd1;
    op    = instr[7:5];
    a     = instr[4:0];
    case (op)
      3'd0: m_acc = m_mem[a];
      3'd1: m_mem[a] = m_acc;
      3'd2: m_acc = m_acc + m_mem[a];
      3'd3: m_acc = m_acc - m_mem[a];
      3'd4: if (m_acc != 8'h00) m_pc = a;
      3'd5: m_acc = switches;
      3'd6: m_out = m_acc;
      default: m_pc = a;
    endcase
  endtask

  // Run one instruction on the DUT and compare visible state to the model.
  task automatic run_instr();
    logic [7:0] o;
    repeat (3) @(posedge clock);
    #1;
    model_step();
    o = m_out;
    check("disp0", {25'd0, disp0}, {25'd0, seg_tab[o[3:0]]});
    check("disp1", {25'd0, disp1}, {25'd0, seg_tab[o[7:4]]});
    check("pc",    {27'd0, dut.pc}, {27'd0, m_pc});
    check("acc",   {24'd0, dut.acc}, {24'd0, m_acc});
  endtask

  // Load a whole memory image into both DUT and model (reset must be held).
  task automatic load_image(input logic [7:0] img [0:31]);
    for (int i = 0; i < 32; i++) begin
      m_mem[i]   = img[i];
      dut.mem[i] = img[i];
    end
  endtask

  logic [7:0] img [0:31];
  logic [7:0] sw_vals [0:2] = '{8'd5, 8'd2, 8'd32};
  logic [6:0] d0_exp  [0:2] = '{7'h6D, 7'h5B, 7'h3F};
  logic [6:0] d1_exp  [0:2] = '{7'h3F, 7'h3F, 7'h5B};

  initial begin
    checks   = 0;
    fails    = 0;
    n_reset  = 1'b1;
    switches = 8'd0;
    model_power_up();
    model_reset();

    // Reset held for two edges
    repeat (2) @(posedge clock);
    #1;
    check("rst_disp0", {25'd0, disp0}, 32'h3F);
    check("rst_disp1", {25'd0, disp1}, 32'h3F);
    check("rst_pc",    {27'd0, dut.pc}, 32'd0);
    check("rst_state", {30'd0, dut.state}, 32'd0);

    // Default program with switches = 3
    switches = 8'd3;
    n_reset  = 1'b0;
    run_instr();
    run_instr();
    check("sw3_disp0", {25'd0, disp0}, 32'h4F);
    check("sw3_disp1", {25'd0, disp1}, 32'h3F);
    run_instr();
    check("edge9_pc", {27'd0, dut.pc}, 32'd0);

    // Directed switch values
    for (int k = 0; k < 3; k++) begin
      switches = sw_vals[k];
      repeat (3) run_instr();
      check("sw_disp0", {25'd0, disp0}, {25'd0, d0_exp[k]});
      check("sw_disp1", {25'd0, disp1}, {25'd0, d1_exp[k]});
    end

    // Random switch values through the default loop
    for (int k = 0; k < 8; k++) begin
      switches = 8'($urandom);
      repeat (3) run_instr();
    end

    // Reset during DECODE of OUT
    switches = 8'h7E;
    repeat (3) run_instr();
    switches = 8'h11;
    run_instr();
    @(posedge clock);
    #1;
    n_reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    check("abort_out_pc",     {27'd0, dut.pc}, 32'd0);
    check("abort_out_outreg", {24'd0, dut.outreg}, 32'd0);
    check("abort_out_disp0",  {25'd0, disp0}, 32'h3F);
    check("abort_out_disp1",  {25'd0, disp1}, 32'h3F);
    check("abort_out_state",  {30'd0, dut.state}, 32'd0);

    // Reset during EXECUTE of STORE must not write memory
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0]  = 8'hA0;
    img[1]  = 8'h34;
    img[2]  = 8'hE0;
    img[20] = 8'h55;
    load_image(img);
    @(posedge clock);
    #1;
    switches = 8'hAA;
    n_reset  = 1'b0;
    run_instr();
    repeat (2) @(posedge clock);
    #1;
    n_reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    check("abort_store_mem", {24'd0, dut.mem[20]}, 32'h55);
    n_reset = 1'b0;
    repeat (3) run_instr();
    check("store_mem", {24'd0, dut.mem[20]}, {24'd0, m_mem[20]});

    // LOAD/ADD/STORE/LOAD/OUT/JMP-self with wrapping add
    n_reset = 1'b1;
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0]  = 8'h0A;
    img[1]  = 8'h4B;
    img[2]  = 8'h2C;
    img[3]  = 8'h0C;
    img[4]  = 8'hC0;
    img[5]  = 8'hE5;
    img[10] = 8'hF0;
    img[11] = 8'h25;
    load_image(img);
    @(posedge clock);
    #1;
    model_reset();
    n_reset = 1'b0;
    repeat (8) run_instr();
    check("add_mem12",  {24'd0, dut.mem[12]}, 32'h15);
    check("add_disp1",  {25'd0, disp1}, 32'h06);
    check("add_disp0",  {25'd0, disp0}, 32'h6D);
    check("jmp_self_pc", {27'd0, dut.pc}, 32'd5);

    // SUB/BNE countdown from 3, then run off the end and wrap
    n_reset = 1'b1;
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0]  = 8'h14;
    img[1]  = 8'h75;
    img[2]  = 8'h81;
    img[20] = 8'h03;
    img[21] = 8'h01;
    load_image(img);
    @(posedge clock);
    #1;
    model_reset();
    n_reset = 1'b0;
    repeat (3) run_instr();
    check("bne_taken2_pc",  {27'd0, dut.pc}, 32'd1);
    check("bne_taken2_acc", {24'd0, dut.acc}, 32'd2);
    repeat (2) run_instr();
    check("bne_taken1_pc",  {27'd0, dut.pc}, 32'd1);
    check("bne_taken1_acc", {24'd0, dut.acc}, 32'd1);
    repeat (2) run_instr();
    check("bne_fall_pc",  {27'd0, dut.pc}, 32'd3);
    check("bne_fall_acc", {24'd0, dut.acc}, 32'd0);
    repeat (29) run_instr();
    check("pc_wrap", {27'd0, dut.pc}, 32'd0);

    // Random programs with random switches
    for (int p = 0; p < 3; p++) begin
      n_reset = 1'b1;
      for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
      load_image(img);
      @(posedge clock);
      #1;
      model_reset();
      n_reset = 1'b0;
      for (int k = 0; k < 60; k++) begin
        switches = 8'($urandom);
        run_instr();
      end
      for (int i = 0; i < 32; i++) begin
        check("rand_mem", {24'd0, dut.mem[i]}, {24'd0, m_mem[i]});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu2.md
CPU2 -- requirements
Module: cpu2

Interface
REQ-001 Parameter WORD_W, default 8: data/instruction word width.
REQ-002 Parameter OP_W, default 3: opcode field width; the address width A_W = WORD_W-OP_W (5 by default).
REQ-003 Port clock, input, 1: single system clock; all state updates on the rising edge.
REQ-004 Port n_reset, input, 1: reset is synchronous and active-high, so n_reset=1 at a rising clock edge resets the block despite the name.
REQ-005 Port switches, input, WORD_W: external input value read by the IN instruction.
REQ-006 Port disp0, output, 7: seven-segment pattern of output-register bits [3:0].
REQ-007 Port disp1, output, 7: seven-segment pattern of output-register bits [7:4].

Function
REQ-008 Internal state: PC (A_W), IR (WORD_W), MAR (A_W), MDR (WORD_W), ACC (WORD_W), OUTREG (WORD_W), sequencer state, and memory of 2^A_W words of WORD_W bits.
REQ-009 Instruction format: IR[WORD_W-1:A_W] is the opcode and IR[A_W-1:0] is the address.
REQ-010 Sequencer states are FETCH -> DECODE -> EXECUTE -> FETCH; every instruction takes exactly 3 cycles.
REQ-011 FETCH: IR <= mem[PC] (asynchronous read), and PC <= PC+1 modulo 2^A_W (31 wraps to 0).
REQ-012 DECODE: MAR <= IR address field, and MDR <= mem[IR address field].
REQ-013 EXECUTE performs one action per opcode, as listed in REQ-014 to REQ-021.
REQ-014 Opcode 000 LOAD: ACC <= MDR.
REQ-015 Opcode 001 STORE: mem[MAR] <= ACC (synchronous write).
REQ-016 Opcode 010 ADD: ACC <= ACC+MDR modulo 2^WORD_W, carry discarded.
REQ-017 Opcode 011 SUB: ACC <= ACC-MDR modulo 2^WORD_W, borrow discarded.
REQ-018 Opcode 100 BNE: if ACC != 0, PC <= MAR; otherwise PC is unchanged.
REQ-019 Opcode 101 IN: ACC <= switches, sampled at the EXECUTE edge.
REQ-020 Opcode 110 OUT: OUTREG <= ACC.
REQ-021 Opcode 111 JMP: PC <= MAR unconditionally.
REQ-022 The address field is ignored by IN and OUT.
REQ-023 Registers not named in an opcode's action hold their value.
REQ-024 Only STORE writes memory.
REQ-025 Memory power-up contents: mem[0]=8'hA0 (IN), mem[1]=8'hC0 (OUT), mem[2]=8'hE0 (JMP 0), and all other words 8'h00; at defaults the program loops every 9 cycles, copying switches to the displays.
REQ-026 Segment encoding is active-high, bit6..bit0 = g,f,e,d,c,b,a.
REQ-027 Digit codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-028 disp0 and disp1 are combinational decodes of OUTREG only.

Reset
REQ-029 Reset values: state=FETCH, PC=0, IR=0, MAR=0, MDR=0, ACC=0, OUTREG=0, which makes disp0=disp1=7'h3F.
REQ-030 Reset overrides any in-progress instruction, including a STORE in EXECUTE (no memory write occurs on the reset edge).
REQ-031 Reset does not alter memory contents.
REQ-032 The first FETCH occurs on the first rising edge with n_reset=0.

Verification
REQ-033 Hold n_reset=1 for 2 edges -> disp0=3F, disp1=3F, PC=0, state FETCH.
REQ-034 Release reset with switches=3 -> after the 6th edge (OUT EXECUTE), disp0=4F and disp1=3F; at edge 9, PC=0.
REQ-035 Set switches=5, then 2, then 32 (each held 9+ cycles) -> displays 6D/3F, then 5B/3F, then disp0=3F and disp1=5B.
REQ-036 Assert n_reset during DECODE of OUT -> next edge PC=0 and OUTREG=0, with no display change from the aborted OUT.
REQ-037 Preload mem: LOAD 10, ADD 11, STORE 12, LOAD 12, OUT, JMP 5 (self-loop), with mem[10]=8'hF0 and mem[11]=8'h25 -> mem[12]=8'h15 (wrap), disp1=06, disp0=6D.
REQ-038 Preload SUB/BNE countdown with ACC from 3 -> loop taken at ACC=2 and 1, falls through at ACC=0, and PC wraps 31 -> 0 when execution runs off the end.
